dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port synchronous data RAM: IDLE -> ACCESS -> RESP.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed m0 priority; the default build uses round-robin.
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic                rd_q, rd_d;
    logic                m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
    logic                m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                pick_m1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    always_comb pick_m1 = m1_req & ~m0_req;
`else
    // last_q = 1 means m1 was granted last, so m0 wins the next tie
    logic last_q, last_d;
    always_comb pick_m1 = m1_req & (~m0_req | ~last_q);
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rd_d        = rd_q;
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d    = ACCESS;
                    sel_d      = pick_m1;
                    m0_gnt_d   = ~pick_m1;
                    m1_gnt_d   = pick_m1;
                    ram_we_d   = pick_m1 ? m1_we    : m0_we;
                    ram_addr_d = pick_m1 ? m1_addr  : m0_addr;
                    ram_din_d  = pick_m1 ? m1_wdata : m0_wdata;
                    rd_d       = pick_m1 ? ~m1_we   : ~m0_we;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    last_d     = pick_m1;
`endif
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                if (rd_q) begin
                    if (sel_q) begin
                        m1_rvalid_d = 1'b1;
                        m1_rdata_d  = ram_dout;
                    end else begin
                        m0_rvalid_d = 1'b1;
                        m0_rdata_d  = ram_dout;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            rd_q        <= 1'b0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rd_q        <= rd_d;
            m0_gnt_q    <= m0_gnt_d;
            m1_gnt_q    <= m1_gnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign m0_gnt    = m0_gnt_q;
    assign m1_gnt    = m1_gnt_q;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter against a transaction-timing model plus a RAM model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        RSTN = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [9:0]  m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we, busy;
    logic [31:0] m0_rdata, m1_rdata, ram_din;
    logic [31:0] ram_dout = '0;
    logic [9:0]  ram_addr;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .RSTN(RSTN),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int n_err = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a grant at edge g occupies the RAM until g+3; read data lands at g+2.
    logic [31:0] shadow [1024];
    int          cyc = 0;
    int          last_g = -100;
    bit          last_m = 1'b1;
    bit          pend_rd = 1'b0;
    int          pend_g = 0;
    bit          pend_m = 1'b0;
    logic [31:0] pend_data = '0;
    logic [1:0]  e_gnt = '0, e_rv = '0;
    logic        e_we = 1'b0, e_busy = 1'b0;
    logic [9:0]  e_addr = '0;
    logic [31:0] e_din = '0, e_rd0 = '0, e_rd1 = '0;

    task automatic model_update();
        bit          w;
        logic        we_w;
        logic [9:0]  a_w;
        logic [31:0] d_w;
        cyc++;
        e_gnt = '0;
        e_rv  = '0;
        e_we  = 1'b0;
        if (!RSTN) begin
            last_g  = -100;
            last_m  = 1'b1;
            pend_rd = 1'b0;
            e_addr  = '0;
            e_din   = '0;
            e_rd0   = '0;
            e_rd1   = '0;
        end else begin
            if (pend_rd && cyc == pend_g + 2) begin
                e_rv[pend_m] = 1'b1;
                if (pend_m) e_rd1 = pend_data; else e_rd0 = pend_data;
                pend_rd = 1'b0;
            end
            if (cyc >= last_g + 3 && (m0_req || m1_req)) begin
                if (m0_req && m1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    w = 1'b0;
`else
                    w = ~last_m;
`endif
                end else begin
                    w = m1_req;
                end
                we_w = w ? m1_we : m0_we;
                a_w  = w ? m1_addr : m0_addr;
                d_w  = w ? m1_wdata : m0_wdata;
                e_gnt[w] = 1'b1;
                e_we     = we_w;
                e_addr   = a_w;
                e_din    = d_w;
                if (we_w) shadow[a_w] = d_w;
                else begin
                    pend_rd   = 1'b1;
                    pend_g    = cyc;
                    pend_m    = w;
                    pend_data = shadow[a_w];
                end
                last_g = cyc;
                last_m = w;
            end
        end
        e_busy = RSTN && (cyc <= last_g + 1);
    endtask

    task automatic compare();
        check("m0_gnt", m0_gnt, e_gnt[0]);
        check("m1_gnt", m1_gnt, e_gnt[1]);
        check("gnt_excl", m0_gnt & m1_gnt, 0);
        check("m0_rvalid", m0_rvalid, e_rv[0]);
        check("m1_rvalid", m1_rvalid, e_rv[1]);
        check("ram_we", ram_we, e_we);
        check("ram_addr", ram_addr, e_addr);
        check("ram_din", ram_din, e_din);
        check("m0_rdata", m0_rdata, e_rd0);
        check("m1_rdata", m1_rdata, e_rd1);
        check("busy", busy, e_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic rnd_master(input logic granted, inout logic req, inout logic we,
                              inout logic [9:0] addr, inout logic [31:0] wd);
        bit fresh;
        fresh = 1'b0;
        if (req && granted) begin
            req   = ($urandom_range(0, 1) == 1);
            fresh = req;
        end else if (!req && $urandom_range(0, 3) == 0) begin
            req   = 1'b1;
            fresh = 1'b1;
        end
        if (fresh) begin
            we   = ($urandom_range(0, 1) == 1);
            addr = 10'($urandom_range(0, 15));
            wd   = $urandom;
        end
    endtask

    int  g_cyc [4];
    bit  g_who [4];
    int  n_g;
    bit  exp_who;
    int  m0_cnt;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end

        // reset state
        RSTN = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_rdata0", m0_rdata, 0);
        RSTN = 1'b1;
        tick();

        // m0 write 0xDEADBEEF to 0x005
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'h005; m0_wdata = 32'hDEADBEEF;
        tick();
        check("wr_gnt", m0_gnt, 1);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 10'h005);
        check("wr_ram_din", ram_din, 32'hDEADBEEF);
        m0_req = 1'b0;
        tick();
        check("wr_ram_we_off", ram_we, 0);
        tick();
        check("wr_no_rvalid", m0_rvalid, 0);

        // m1 reads it back
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h005;
        tick();
        check("rd_gnt", m1_gnt, 1);
        m1_req = 1'b0;
        tick();
        tick();
        check("rd_rvalid", m1_rvalid, 1);
        check("rd_rdata", m1_rdata, 32'hDEADBEEF);
        check("rd_m0_quiet", m0_rvalid, 0);

        // both masters hold req: grant order and spacing
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h001;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h002;
        n_g = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if ((m0_gnt || m1_gnt) && n_g < 4) begin
                g_cyc[n_g] = cyc;
                g_who[n_g] = m1_gnt;
                n_g++;
            end
        end
        check("rr_count", n_g, 4);
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_who = 1'b0;
`else
            exp_who = (i % 2 == 1);
`endif
            if (i < n_g) check($sformatf("rr_who%0d", i), g_who[i], exp_who);
            if (i > 0 && i < n_g) check($sformatf("rr_gap%0d", i), g_cyc[i] - g_cyc[i-1], 3);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) tick();

        // reset while a read sits in ACCESS
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h005;
        tick();
        check("abort_gnt", m0_gnt, 1);
        m0_req = 1'b0;
        RSTN = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_rvalid", m0_rvalid, 0);
        check("abort_rdata", m0_rdata, 0);
        RSTN = 1'b1;
        repeat (3) tick();

        // randomised traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            rnd_master(e_gnt[0], m0_req, m0_we, m0_addr, m0_wdata);
            rnd_master(e_gnt[1], m1_req, m1_we, m1_addr, m1_wdata);
            RSTN = ($urandom_range(0, 99) != 0);
            tick();
        end

        // m0 alone, request held continuously
        m0_req = 1'b0; m1_req = 1'b0; RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'h00A; m0_wdata = 32'h1234_5678;
        m0_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (m0_gnt) m0_cnt++;
        end
        check("hold_gnt_count", m0_cnt, 10);
        m0_req = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
